dmi_req_ctrl: RTL and testbench

DMI_REQ_CTRL -- requirements
Module: dmi_req_ctrl

---
 rtl/dmi_req_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_dmi_req_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_req_ctrl.sv
// -----------------------------------------------------------------------------
// dmi_req_ctrl
//
// Purpose:
//    Debug Module Interface request controller on the JTAG (TCK) side. Owns the
//    DMI data register (DR = {address, data[31:0], op[1:0]}, op at the LSBs),
//    turns an Update-DR into a single read or write request, collects the
//    response, and keeps the sticky DMI error status reported via DTMCS.
//
// Ports:
//    clk_i, rst_i            TCK and asynchronous active-high reset
//    test_logic_reset_i      TAP Test-Logic-Reset: clears the DR
//    capture_dr_i            TAP Capture-DR strobe
//    shift_dr_i              TAP Shift-DR strobe
//    update_dr_i             TAP Update-DR strobe
//    dmi_access_i            IR selects DMI
//    dtmcs_select_i          IR selects DTMCS
//    dmi_reset_i             DTMCS dmireset bit (clears sticky error)
//    dmi_tdi_i / dmi_tdo_o   serial data in / out (tdo = DR[0])
//    dmi_error_o             sticky status: 0 none, 2 op failed, 3 busy
//    req_*                   request channel towards the debug module
//    resp_*                  response channel from the debug module
//    dbg_state_o             current FSM state (for checkers / debug)
//
// Handshake semantics (both channels):
//    A beat transfers on a rising edge where valid and ready are both high.
//    The request side raises req_valid_o one cycle after an accepted Update-DR
//    and holds req_addr_o/req_data_o/req_op_o stable until req_ready_i.
//    resp_ready_o is tied high; a response beat is consumed only while waiting
//    for one, otherwise it is dropped without side effects.
// -----------------------------------------------------------------------------
module dmi_req_ctrl #(
   parameter int unsigned AddrWidth     = 7,
   parameter bit          WaitWriteResp = 1'b0,
   parameter int unsigned TimeoutCycles = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 test_logic_reset_i,
   input  logic                 capture_dr_i,
   input  logic                 shift_dr_i,
   input  logic                 update_dr_i,
   input  logic                 dmi_access_i,
   input  logic                 dtmcs_select_i,
   input  logic                 dmi_reset_i,
   input  logic                 dmi_tdi_i,
   output logic                 dmi_tdo_o,
   output logic [1:0]           dmi_error_o,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic [AddrWidth-1:0] req_addr_o,
   output logic [31:0]          req_data_o,
   output logic [1:0]           req_op_o,
   input  logic                 resp_valid_i,
   output logic                 resp_ready_o,
   input  logic [31:0]          resp_data_i,
   input  logic [1:0]           resp_status_i,
   output logic [2:0]           dbg_state_o
);

   localparam int unsigned DrW = AddrWidth + 34;

   // Last count value before the wait is abandoned; unused when TimeoutCycles==0.
   localparam logic [15:0] TimeoutLast =
      (TimeoutCycles == 0) ? 16'd0 : 16'(TimeoutCycles - 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_READ       = 3'd1,
      ST_WAIT_READ  = 3'd2,
      ST_WRITE      = 3'd3,
      ST_WAIT_WRITE = 3'd4
   } state_e;

   state_e                r_state;
   logic [DrW-1:0]        r_dr;
   logic [AddrWidth-1:0]  r_addr;
   logic [31:0]           r_data;
   logic [1:0]            r_error;
   logic [15:0]           r_cnt;

   state_e                w_next_state;
   logic                  w_update;
   logic                  w_capture;
   logic                  w_shift;
   logic                  w_busy;
   logic [1:0]            w_cap_status;
   logic                  w_latch_req;
   logic                  w_resp_take;
   logic                  w_fail;
   logic                  w_timeout_hit;
   logic                  w_err_clear;
   logic                  w_in_wait;

   // ---------------------------------------------------------------------------
   // Strobe qualification and busy detection
   // ---------------------------------------------------------------------------
   always_comb begin
      w_update  = update_dr_i  & dmi_access_i;
      w_capture = capture_dr_i & dmi_access_i;
      w_shift   = shift_dr_i   & dmi_access_i;

      // Capturing while a write request is still being offered is not busy:
      // the data field captured then is the write data, which is still valid.
      w_busy = (w_update & (r_state != ST_IDLE)) |
               (w_capture & ((r_state == ST_READ) |
                             (r_state == ST_WAIT_READ) |
                             (r_state == ST_WAIT_WRITE)));

      if (r_error != 2'd0) begin
         w_cap_status = r_error;
      end else if (w_busy) begin
         w_cap_status = 2'd3;
      end else begin
         w_cap_status = 2'd0;
      end

      w_in_wait     = (r_state == ST_WAIT_READ) | (r_state == ST_WAIT_WRITE);
      w_timeout_hit = (TimeoutCycles != 0) && (r_cnt == TimeoutLast);
      w_err_clear   = dmi_reset_i & dtmcs_select_i;
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and request outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_latch_req  = 1'b0;
      w_resp_take  = 1'b0;
      w_fail       = 1'b0;
      req_valid_o  = 1'b0;
      req_op_o     = 2'd0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_update && (r_error == 2'd0)) begin
               w_latch_req = 1'b1;
               if (r_dr[1:0] == 2'd1) begin
                  w_next_state = ST_READ;
               end else if (r_dr[1:0] == 2'd2) begin
                  w_next_state = ST_WRITE;
               end
            end
         end
         ST_READ: begin
            req_valid_o = 1'b1;
            req_op_o    = 2'd1;
            if (req_ready_i) begin
               w_next_state = ST_WAIT_READ;
            end
         end
         ST_WRITE: begin
            req_valid_o = 1'b1;
            req_op_o    = 2'd2;
            if (req_ready_i) begin
               w_next_state = WaitWriteResp ? ST_WAIT_WRITE : ST_IDLE;
            end
         end
         ST_WAIT_READ, ST_WAIT_WRITE: begin
            if (resp_valid_i) begin
               w_next_state = ST_IDLE;
               w_resp_take  = 1'b1;
               w_fail       = (resp_status_i != 2'd0);
            end else if (w_timeout_hit) begin
               w_next_state = ST_IDLE;
               w_fail       = 1'b1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_dr    <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_error <= 2'd0;
         r_cnt   <= 16'd0;
      end else begin
         r_state <= w_next_state;

         // Test-Logic-Reset outranks shift, which outranks capture.
         if (test_logic_reset_i) begin
            r_dr <= '0;
         end else if (w_shift) begin
            r_dr <= {dmi_tdi_i, r_dr[DrW-1:1]};
         end else if (w_capture) begin
            r_dr <= {r_addr, r_data, w_cap_status};
         end

         if (w_latch_req) begin
            r_addr <= r_dr[DrW-1:34];
            r_data <= r_dr[33:2];
         end else if (w_resp_take && (r_state == ST_WAIT_READ)) begin
            r_data <= resp_data_i;
         end

         // First error wins; an explicit clear beats a same-cycle set.
         if (w_err_clear) begin
            r_error <= 2'd0;
         end else if ((r_error == 2'd0) && (w_fail || w_busy)) begin
            r_error <= w_fail ? 2'd2 : 2'd3;
         end

         if (w_in_wait && (w_next_state == r_state)) begin
            r_cnt <= r_cnt + 16'd1;
         end else begin
            r_cnt <= 16'd0;
         end
      end
   end

   assign dmi_tdo_o    = r_dr[0];
   assign dmi_error_o  = r_error;
   assign req_addr_o   = r_addr;
   assign req_data_o   = r_data;
   assign resp_ready_o = 1'b1;
   assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_dmi_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmi_req_ctrl
//
// Purpose:
//    Directed self-checking bench for dmi_req_ctrl. Two instances share the TAP
//    strobes and the request/response inputs; each is enabled by its own
//    dmi_access line:
//       u_dut_a  AddrWidth=7,  TimeoutCycles=8, WaitWriteResp=0
//       u_dut_b  AddrWidth=16, TimeoutCycles=0, WaitWriteResp=0
//    State encoding seen on dbg_state_o: 0 Idle, 1 Read, 2 WaitRead,
//    3 Write, 4 WaitWrite.
// -----------------------------------------------------------------------------
module tb_dmi_req_ctrl;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_WREAD = 3'd2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic tlr = 1'b0, capture = 1'b0, shift = 1'b0, update = 1'b0;
   logic access_a = 1'b0, access_b = 1'b0;
   logic dtmcs_sel = 1'b0, dmi_reset = 1'b0, tdi = 1'b0;
   logic req_ready = 1'b0, resp_valid = 1'b0;
   logic [31:0] resp_data = 32'h0;
   logic [1:0]  resp_status = 2'd0;
   logic sel_b = 1'b0;

   // ---------------- DUT A outputs ----------------
   logic        tdo_a, req_valid_a, resp_ready_a;
   logic [1:0]  err_a, op_a;
   logic [6:0]  addr_a;
   logic [31:0] data_a;
   logic [2:0]  st_a;

   // ---------------- DUT B outputs ----------------
   logic        tdo_b, req_valid_b, resp_ready_b;
   logic [1:0]  err_b, op_b;
   logic [15:0] addr_b;
   logic [31:0] data_b;
   logic [2:0]  st_b;

   logic tdo_mux;
   assign tdo_mux = sel_b ? tdo_b : tdo_a;

   dmi_req_ctrl #(.AddrWidth(7), .WaitWriteResp(1'b0), .TimeoutCycles(8)) u_dut_a (
      .clk_i(clk), .rst_i(rst),
      .test_logic_reset_i(tlr), .capture_dr_i(capture), .shift_dr_i(shift),
      .update_dr_i(update), .dmi_access_i(access_a), .dtmcs_select_i(dtmcs_sel),
      .dmi_reset_i(dmi_reset), .dmi_tdi_i(tdi), .dmi_tdo_o(tdo_a),
      .dmi_error_o(err_a), .req_valid_o(req_valid_a), .req_ready_i(req_ready),
      .req_addr_o(addr_a), .req_data_o(data_a), .req_op_o(op_a),
      .resp_valid_i(resp_valid), .resp_ready_o(resp_ready_a),
      .resp_data_i(resp_data), .resp_status_i(resp_status), .dbg_state_o(st_a)
   );

   dmi_req_ctrl #(.AddrWidth(16), .WaitWriteResp(1'b0), .TimeoutCycles(0)) u_dut_b (
      .clk_i(clk), .rst_i(rst),
      .test_logic_reset_i(tlr), .capture_dr_i(capture), .shift_dr_i(shift),
      .update_dr_i(update), .dmi_access_i(access_b), .dtmcs_select_i(dtmcs_sel),
      .dmi_reset_i(dmi_reset), .dmi_tdi_i(tdi), .dmi_tdo_o(tdo_b),
      .dmi_error_o(err_b), .req_valid_o(req_valid_b), .req_ready_i(req_ready),
      .req_addr_o(addr_b), .req_data_o(data_b), .req_op_o(op_b),
      .resp_valid_i(resp_valid), .resp_ready_o(resp_ready_b),
      .resp_data_i(resp_data), .resp_status_i(resp_status), .dbg_state_o(st_b)
   );

   // ---------------- scoreboard counters ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Capture-DR, shift w bits LSB first (collecting tdo), optional Update-DR.
   // Returns 1 time unit after the last edge it used.
   task automatic scan(input logic [63:0] din, input int w, input bit do_upd,
                       output logic [63:0] dout);
      dout = 64'h0;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      shift   = 1'b1;
      for (int i = 0; i < w; i++) begin
         dout[i] = tdo_mux;
         tdi     = din[i];
         tick();
      end
      shift = 1'b0;
      tdi   = 1'b0;
      if (do_upd) begin
         update = 1'b1;
         tick();
         update = 1'b0;
      end
   endtask

   task automatic clear_err();
      dtmcs_sel = 1'b1;
      dmi_reset = 1'b1;
      tick();
      dtmcs_sel = 1'b0;
      dmi_reset = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d, input logic [1:0] s);
      resp_valid  = 1'b1;
      resp_data   = d;
      resp_status = s;
      tick();
      resp_valid  = 1'b0;
      resp_data   = 32'h0;
      resp_status = 2'd0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   logic [63:0] dout;

   initial begin
      // Reset state (checked while reset is asserted)
      rst = 1'b1;
      #12;
      check_eq("rst_valid_a", {63'h0, req_valid_a}, 64'h0);
      check_eq("rst_tdo_a",   {63'h0, tdo_a}, 64'h0);
      check_eq("rst_err_a",   {62'h0, err_a}, 64'h0);
      check_eq("rst_rready_a",{63'h0, resp_ready_a}, 64'h1);
      check_eq("rst_state_a", {61'h0, st_a}, {61'h0, S_IDLE});
      check_eq("rst_valid_b", {63'h0, req_valid_b}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // ---- Read: addr 0x11, response 0xDEADBEEF ----
      access_a  = 1'b1;
      req_ready = 1'b1;
      scan({7'h11, 32'h0, 2'd1}, 41, 1'b1, dout);
      check_eq("rd_first_cap", dout, 64'h0);
      check_eq("rd_valid",     {63'h0, req_valid_a}, 64'h1);
      check_eq("rd_op",        {62'h0, op_a}, 64'h1);
      check_eq("rd_addr",      {57'h0, addr_a}, 64'h11);
      tick();
      check_eq("rd_wait_state",{61'h0, st_a}, {61'h0, S_WREAD});
      check_eq("rd_wait_valid",{63'h0, req_valid_a}, 64'h0);
      tick();
      tick();
      respond(32'hDEADBEEF, 2'd0);
      check_eq("rd_done_state",{61'h0, st_a}, {61'h0, S_IDLE});
      check_eq("rd_done_err",  {62'h0, err_a}, 64'h0);
      // DR still holds the shifted word (op=1 at bit 0); TLR clears it
      check_eq("tlr_before",   {63'h0, tdo_a}, 64'h1);
      tlr = 1'b1;
      tick();
      tlr = 1'b0;
      check_eq("tlr_after",    {63'h0, tdo_a}, 64'h0);
      scan(64'h0, 41, 1'b0, dout);
      check_eq("rd_cap", dout, {23'h0, 7'h11, 32'hDEADBEEF, 2'd0});

      // ---- Write: addr 0x10, data 0x5, no response wait ----
      scan({7'h10, 32'h5, 2'd2}, 41, 1'b1, dout);
      check_eq("wr_valid", {63'h0, req_valid_a}, 64'h1);
      check_eq("wr_op",    {62'h0, op_a}, 64'h2);
      check_eq("wr_addr",  {57'h0, addr_a}, 64'h10);
      check_eq("wr_data",  {32'h0, data_a}, 64'h5);
      tick();
      check_eq("wr_idle",  {61'h0, st_a}, {61'h0, S_IDLE});
      check_eq("wr_novalid",{63'h0, req_valid_a}, 64'h0);
      check_eq("wr_err",   {62'h0, err_a}, 64'h0);

      // ---- Busy: Update-DR while in WaitRead ----
      scan({7'h12, 32'h0, 2'd1}, 41, 1'b1, dout);
      check_eq("busy_prev_cap", dout, {23'h0, 7'h10, 32'h5, 2'd0});
      tick();
      update = 1'b1;
      tick();
      update = 1'b0;
      check_eq("busy_err",   {62'h0, err_a}, 64'h3);
      check_eq("busy_state", {61'h0, st_a}, {61'h0, S_WREAD});
      respond(32'hCAFEF00D, 2'd0);
      check_eq("busy_done",  {61'h0, st_a}, {61'h0, S_IDLE});
      scan({7'h13, 32'h0, 2'd1}, 41, 1'b1, dout);
      check_eq("busy_cap", dout, {23'h0, 7'h12, 32'hCAFEF00D, 2'd3});
      check_eq("busy_upd_ignored", {61'h0, st_a}, {61'h0, S_IDLE});
      tick();
      check_eq("busy_no_req", {63'h0, req_valid_a}, 64'h0);
      clear_err();
      check_eq("busy_clear", {62'h0, err_a}, 64'h0);

      // ---- Capture during WaitRead: status 3, later timeout loses ----
      scan({7'h14, 32'h0, 2'd1}, 41, 1'b1, dout);
      tick();
      scan(64'h0, 41, 1'b0, dout);
      check_eq("cap_busy_status", dout, {23'h0, 7'h14, 32'h0, 2'd3});
      check_eq("cap_busy_first_wins", {62'h0, err_a}, 64'h3);
      check_eq("cap_busy_timed_out", {61'h0, st_a}, {61'h0, S_IDLE});
      clear_err();

      // ---- Timeout after 8 wait cycles ----
      scan({7'h15, 32'h12345678, 2'd1}, 41, 1'b1, dout);
      check_eq("to_read_state", {61'h0, st_a}, {61'h0, S_READ});
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq("to_waiting", {61'h0, st_a}, {61'h0, S_WREAD});
      end
      tick();
      check_eq("to_idle", {61'h0, st_a}, {61'h0, S_IDLE});
      check_eq("to_err",  {62'h0, err_a}, 64'h2);
      respond(32'hBAD0BAD0, 2'd2);
      check_eq("late_state", {61'h0, st_a}, {61'h0, S_IDLE});
      clear_err();
      scan(64'h0, 41, 1'b0, dout);
      check_eq("late_cap", dout, {23'h0, 7'h15, 32'h12345678, 2'd0});

      // ---- Failed response ----
      scan({7'h16, 32'h0, 2'd1}, 41, 1'b1, dout);
      tick();
      respond(32'h0BADF00D, 2'd2);
      check_eq("fail_err",   {62'h0, err_a}, 64'h2);
      check_eq("fail_state", {61'h0, st_a}, {61'h0, S_IDLE});
      scan(64'h0, 41, 1'b0, dout);
      check_eq("fail_cap", dout, {23'h0, 7'h16, 32'h0BADF00D, 2'd2});
      clear_err();
      check_eq("fail_clear", {62'h0, err_a}, 64'h0);

      // ---- Busy and clear in the same cycle: clear wins ----
      scan({7'h17, 32'h0, 2'd1}, 41, 1'b1, dout);
      tick();
      update    = 1'b1;
      dtmcs_sel = 1'b1;
      dmi_reset = 1'b1;
      tick();
      update    = 1'b0;
      dtmcs_sel = 1'b0;
      dmi_reset = 1'b0;
      check_eq("busyclr_err",   {62'h0, err_a}, 64'h0);
      check_eq("busyclr_state", {61'h0, st_a}, {61'h0, S_WREAD});
      respond(32'h1, 2'd0);
      check_eq("busyclr_done",  {61'h0, st_a}, {61'h0, S_IDLE});

      // ---- Reset in the middle of a Read ----
      req_ready = 1'b0;
      scan({7'h18, 32'h77, 2'd1}, 41, 1'b1, dout);
      tick();
      check_eq("mid_valid_held", {63'h0, req_valid_a}, 64'h1);
      check_eq("mid_addr_held",  {57'h0, addr_a}, 64'h18);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_valid", {63'h0, req_valid_a}, 64'h0);
      check_eq("mid_rst_state", {61'h0, st_a}, {61'h0, S_IDLE});
      check_eq("mid_rst_tdo",   {63'h0, tdo_a}, 64'h0);
      check_eq("mid_rst_addr",  {57'h0, addr_a}, 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_ready = 1'b1;
      tick();
      tick();
      tick();
      check_eq("post_rst_valid", {63'h0, req_valid_a}, 64'h0);
      scan(64'h0, 41, 1'b0, dout);
      check_eq("post_rst_cap", dout, 64'h0);

      // ---- AddrWidth=16 instance, no timeout ----
      access_a = 1'b0;
      access_b = 1'b1;
      sel_b    = 1'b1;
      scan({16'h1234, 32'hA5A50F0F, 2'd1}, 50, 1'b1, dout);
      check_eq("b_valid", {63'h0, req_valid_b}, 64'h1);
      check_eq("b_addr",  {48'h0, addr_b}, 64'h1234);
      check_eq("b_op",    {62'h0, op_b}, 64'h1);
      check_eq("b_a_idle",{61'h0, st_a}, {61'h0, S_IDLE});
      tick();
      for (int i = 0; i < 20; i++) tick();
      check_eq("b_no_timeout", {61'h0, st_b}, {61'h0, S_WREAD});
      respond(32'hDEADBEEF, 2'd0);
      check_eq("b_done", {61'h0, st_b}, {61'h0, S_IDLE});
      scan(64'h0, 50, 1'b0, dout);
      check_eq("b_cap", dout, {14'h0, 16'h1234, 32'hDEADBEEF, 2'd0});
      check_eq("b_err", {62'h0, err_b}, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
